// File: rtl/tdp18k_port_arbiter.sv
// Port-A sharer for a TDP18K RAM: round-robin arbitration between two masters,
// read-data routing to the owner one cycle later, and a clear sweep after reset or on request.
module tdp18k_port_arbiter #(
  parameter int          DEPTH_LOG2     = 10,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter logic [17:0] CLEAR_VALUE    = 18'h00000
) (
  input  logic                  CLK_i,
  input  logic                  RESET_ni,
  input  logic                  CLEAR_i,
  output logic                  BUSY_o,
  input  logic                  REQ_0_i,
  input  logic                  REQ_1_i,
  input  logic                  WE_0_i,
  input  logic                  WE_1_i,
  input  logic [DEPTH_LOG2-1:0] ADDR_0_i,
  input  logic [DEPTH_LOG2-1:0] ADDR_1_i,
  input  logic [17:0]           WDATA_0_i,
  input  logic [17:0]           WDATA_1_i,
  input  logic [1:0]            BE_0_i,
  input  logic [1:0]            BE_1_i,
  output logic                  GNT_0_o,
  output logic                  GNT_1_o,
  output logic                  RVALID_0_o,
  output logic                  RVALID_1_o,
  output logic [17:0]           RDATA_0_o,
  output logic [17:0]           RDATA_1_o,
  output logic                  RAM_WEN_o,
  output logic                  RAM_REN_o,
  output logic [13:0]           RAM_ADDR_o,
  output logic [1:0]            RAM_BE_o,
  output logic [17:0]           RAM_WDATA_o,
  input  logic [17:0]           RAM_RDATA_i,
  output logic [2:0]            RAM_WMODE_o,
  output logic [2:0]            RAM_RMODE_o,
  output logic                  RAM_FMODE_o
);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;
  logic                  ptr_q, ptr_d;
  logic                  rvalid0_q, rvalid0_d;
  logic                  rvalid1_q, rvalid1_d;

  logic                  gnt0, gnt1, ramWen, ramRen;
  logic [DEPTH_LOG2-1:0] selAddr;
  logic [9:0]            wordAddr;
  logic [1:0]            ramBe;
  logic [17:0]           ramWdata;

  // ptr_q = 1 means requester 1 is preferred on the next tie.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    ramWen   = 1'b0;
    ramRen   = 1'b0;
    selAddr  = '0;
    ramBe    = 2'b00;
    ramWdata = '0;
    case (state_q)
      ST_CLEAR: begin
        ramWen   = 1'b1;
        ramBe    = 2'b11;
        ramWdata = CLEAR_VALUE;
        selAddr  = cnt_q;
        cnt_d    = cnt_q + 1'b1;
        if (&cnt_q) state_d = ST_IDLE;
      end
      default: begin
        if (CLEAR_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else begin
          gnt0 = REQ_0_i & (~REQ_1_i | ~ptr_q);
          gnt1 = REQ_1_i & (~REQ_0_i | ptr_q);
          if (gnt0) begin
            selAddr  = ADDR_0_i;
            ramWen   = WE_0_i;
            ramRen   = ~WE_0_i;
            ramBe    = BE_0_i;
            ramWdata = WDATA_0_i;
            ptr_d    = 1'b1;
          end else if (gnt1) begin
            selAddr  = ADDR_1_i;
            ramWen   = WE_1_i;
            ramRen   = ~WE_1_i;
            ramBe    = BE_1_i;
            ramWdata = WDATA_1_i;
            ptr_d    = 1'b0;
          end
        end
      end
    endcase
    // Keep the RAM and the masters quiet while reset is held.
    if (!RESET_ni) begin
      gnt0   = 1'b0;
      gnt1   = 1'b0;
      ramWen = 1'b0;
      ramRen = 1'b0;
    end
    rvalid0_d = gnt0 & ~WE_0_i;
    rvalid1_d = gnt1 & ~WE_1_i;
  end

  always_ff @(posedge CLK_i or negedge RESET_ni) begin
    if (!RESET_ni) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      cnt_q     <= '0;
      ptr_q     <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  assign wordAddr    = 10'(selAddr);
  assign BUSY_o      = (state_q == ST_CLEAR);
  assign GNT_0_o     = gnt0;
  assign GNT_1_o     = gnt1;
  assign RVALID_0_o  = rvalid0_q;
  assign RVALID_1_o  = rvalid1_q;
  assign RDATA_0_o   = rvalid0_q ? RAM_RDATA_i : 18'h00000;
  assign RDATA_1_o   = rvalid1_q ? RAM_RDATA_i : 18'h00000;
  assign RAM_WEN_o   = ramWen;
  assign RAM_REN_o   = ramRen;
  assign RAM_ADDR_o  = {wordAddr, 4'b0000};
  assign RAM_BE_o    = ramBe;
  assign RAM_WDATA_o = ramWdata;
  assign RAM_WMODE_o = 3'b010;
  assign RAM_RMODE_o = 3'b010;
  assign RAM_FMODE_o = 1'b0;

endmodule

// File: tb/tb_tdp18k_port_arbiter.sv
// Directed bench for tdp18k_port_arbiter with a behavioural x18 RAM model on port A.
module tb_tdp18k_port_arbiter;

  logic        clk = 1'b0;
  logic        rstN;
  logic        clearPulse;
  logic        busy;
  logic        req0, req1, we0, we1;
  logic [9:0]  addr0, addr1;
  logic [17:0] wdata0, wdata1;
  logic [1:0]  be0, be1;
  logic        gnt0, gnt1, rv0, rv1;
  logic [17:0] rdata0, rdata1;
  logic        ramWen, ramRen;
  logic [13:0] ramAddr;
  logic [1:0]  ramBe;
  logic [17:0] ramWdata;
  logic [17:0] ramRdata;
  logic [2:0]  ramWmode, ramRmode;
  logic        ramFmode;

  logic [17:0] mem [1024];
  int checks = 0;
  int errors = 0;

  tdp18k_port_arbiter dut (
    .CLK_i(clk), .RESET_ni(rstN), .CLEAR_i(clearPulse), .BUSY_o(busy),
    .REQ_0_i(req0), .REQ_1_i(req1), .WE_0_i(we0), .WE_1_i(we1),
    .ADDR_0_i(addr0), .ADDR_1_i(addr1), .WDATA_0_i(wdata0), .WDATA_1_i(wdata1),
    .BE_0_i(be0), .BE_1_i(be1), .GNT_0_o(gnt0), .GNT_1_o(gnt1),
    .RVALID_0_o(rv0), .RVALID_1_o(rv1), .RDATA_0_o(rdata0), .RDATA_1_o(rdata1),
    .RAM_WEN_o(ramWen), .RAM_REN_o(ramRen), .RAM_ADDR_o(ramAddr), .RAM_BE_o(ramBe),
    .RAM_WDATA_o(ramWdata), .RAM_RDATA_i(ramRdata), .RAM_WMODE_o(ramWmode),
    .RAM_RMODE_o(ramRmode), .RAM_FMODE_o(ramFmode)
  );

  always #5 clk = ~clk;

  // Port A of the primitive: byte-lane writes, registered read data.
  always @(posedge clk) begin
    if (ramWen) begin
      if (ramBe[0]) begin
        mem[ramAddr[13:4]][16]  <= ramWdata[16];
        mem[ramAddr[13:4]][7:0] <= ramWdata[7:0];
      end
      if (ramBe[1]) begin
        mem[ramAddr[13:4]][17]   <= ramWdata[17];
        mem[ramAddr[13:4]][15:8] <= ramWdata[15:8];
      end
    end
    if (ramRen) ramRdata <= mem[ramAddr[13:4]];
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  function automatic logic [6:0] flags();
    return {busy, ramWen, ramRen, gnt0, gnt1, rv0, rv1};
  endfunction

  function automatic logic [63:0] sweepView();
    return {23'b0, flags(), ramBe, ramAddr, ramWdata};
  endfunction

  // One accepted access by a single requester; returns with REQ dropped, inside the following cycle.
  task automatic applyStimulus(input int port, input logic we, input logic [9:0] addr,
                               input logic [17:0] data, input logic [1:0] be);
    if (port == 0) begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = data; be0 = be;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = data; be1 = be;
    end
    #1;
    checkOutput("acc_gnt", {62'b0, gnt0, gnt1}, (port == 0) ? 64'd2 : 64'd1);
    checkOutput("acc_en", {62'b0, ramWen, ramRen}, we ? 64'd2 : 64'd1);
    checkOutput("acc_addr", {50'b0, ramAddr}, {50'b0, addr, 4'b0000});
    @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b0;
    #1;
  endtask

  // Expects n consecutive sweep writes starting at address 0 with no grants or read data.
  task automatic runSweep(input int n);
    logic [9:0] a;
    for (int i = 0; i < n; i++) begin
      #1;
      a = i[9:0];
      checkOutput("sweep", sweepView(), {23'b0, 7'b1100000, 2'b11, a, 4'b0000, 18'h00000});
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 18'h3FFFF;
    rstN = 1'b0; clearPulse = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 10'd5; addr1 = 10'd7; wdata0 = '0; wdata1 = '0; be0 = 2'b11; be1 = 2'b11;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_flags", {57'b0, flags()}, {57'b0, 7'b1000000});
    checkOutput("rst_rdata", {28'b0, rdata0, rdata1}, 64'd0);
    checkOutput("const_modes", {57'b0, ramWmode, ramRmode, ramFmode}, {57'b0, 3'b010, 3'b010, 1'b0});

    // Reset sweep with both masters requesting, then alternate grants on the ties.
    rstN = 1'b1;
    runSweep(1024);
    for (int c = 0; c < 4; c++) begin
      #1;
      checkOutput("cont_gnt", {62'b0, gnt0, gnt1}, (c % 2 == 0) ? 64'd2 : 64'd1);
      checkOutput("cont_addr", {50'b0, ramAddr}, (c % 2 == 0) ? 64'h50 : 64'h70);
      if (c > 0) begin
        checkOutput("cont_rv", {62'b0, rv0, rv1}, (c % 2 == 1) ? 64'd2 : 64'd1);
        checkOutput("cont_rdata", {28'b0, rdata0, rdata1}, 64'd0);
      end
      @(negedge clk);
    end
    req0 = 1'b0; req1 = 1'b0;
    #1;
    checkOutput("cont_last_rv", {62'b0, rv0, rv1}, 64'd1);
    @(negedge clk);
    #1;
    checkOutput("cont_rv_off", {62'b0, rv0, rv1}, 64'd0);

    // Single requester write then read back.
    applyStimulus(0, 1'b1, 10'd10, 18'h2A5A5, 2'b11);
    applyStimulus(0, 1'b0, 10'd10, 18'h0, 2'b11);
    checkOutput("rd_rv", {62'b0, rv0, rv1}, 64'd2);
    checkOutput("rd_data0", {46'b0, rdata0}, 64'h2A5A5);
    checkOutput("rd_data1", {46'b0, rdata1}, 64'd0);
    @(negedge clk);
    #1;
    checkOutput("rd_rv_off", {44'b0, rv0, rv1, rdata0}, 64'd0);

    // Byte lanes: clearing lane 0 leaves bit 17 and bits 15:8.
    applyStimulus(0, 1'b1, 10'd3, 18'h3FFFF, 2'b11);
    applyStimulus(0, 1'b1, 10'd3, 18'h00000, 2'b01);
    applyStimulus(0, 1'b0, 10'd3, 18'h0, 2'b11);
    checkOutput("be_data", {46'b0, rdata0}, 64'h2FF00);

    // Per-owner routing under contention; requester 0 went last so requester 1 wins first.
    applyStimulus(0, 1'b1, 10'd20, 18'h11111, 2'b11);
    applyStimulus(1, 1'b1, 10'd21, 18'h02222, 2'b11);
    applyStimulus(0, 1'b0, 10'd20, 18'h0, 2'b11);
    checkOutput("own_rd0", {46'b0, rdata0}, 64'h11111);
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'd20;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'd21;
    #1;
    checkOutput("rr_gnt_a", {62'b0, gnt0, gnt1}, 64'd1);
    @(negedge clk);
    #1;
    checkOutput("rr_gnt_b", {62'b0, gnt0, gnt1}, 64'd2);
    checkOutput("rr_rv1", {44'b0, rv0, rv1, rdata1}, {44'b0, 2'b01, 18'h02222});
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    #1;
    checkOutput("rr_rv0", {44'b0, rv0, rv1, rdata0}, {44'b0, 2'b10, 18'h11111});

    // Clear command while a read is in flight.
    applyStimulus(1, 1'b0, 10'd21, 18'h0, 2'b11);
    clearPulse = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'd20;
    #1;
    checkOutput("clr_gnt", {62'b0, gnt0, gnt1}, 64'd0);
    checkOutput("clr_rv1", {44'b0, rv0, rv1, rdata1}, {44'b0, 2'b01, 18'h02222});
    @(negedge clk);
    clearPulse = 1'b0;
    runSweep(1024);
    #1;
    checkOutput("post_clr_gnt", {61'b0, busy, gnt0, gnt1}, 64'd2);
    @(negedge clk);
    req0 = 1'b0;
    #1;
    checkOutput("post_clr_rd", {45'b0, rv0, rdata0}, {45'b0, 1'b1, 18'h00000});

    // Reset during a sweep restarts it from address 0 and resets the pointer.
    clearPulse = 1'b1;
    req0 = 1'b1; req1 = 1'b1; addr0 = 10'd5; addr1 = 10'd7;
    @(negedge clk);
    clearPulse = 1'b0;
    runSweep(300);
    #1;
    checkOutput("mid_cnt", {50'b0, ramAddr}, {50'b0, 10'd300, 4'b0000});
    rstN = 1'b0;
    #1;
    checkOutput("mid_rst_flags", {57'b0, flags()}, {57'b0, 7'b1000000});
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    runSweep(1024);
    #1;
    checkOutput("rst2_gnt", {61'b0, busy, gnt0, gnt1}, 64'd2);
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdp18k_port_arbiter.md
# tdp18k_port_arbiter

Two-requester arbiter and sequencer for port A of a TDP18K_FIFO used in RAM mode (FMODE low). It shares the single read/write port between two on-chip masters with round-robin fairness and tracks the 1-cycle read latency to route read data back to its owner. It also sweeps the array with a clear value after reset or on command, so the primitive never returns uninitialised contents. Port B of the primitive is not touched by this block.

## Interface

Parameters:
- DEPTH_LOG2, 10, word address width; the array holds 2^DEPTH_LOG2 18-bit words.
- CLEAR_ON_RESET, 1, when 1 a clear sweep starts on reset release.
- CLEAR_VALUE, 18'h00000, data written during a clear sweep.

Ports:
- CLK_i  in  1  single clock; also drives the RAM port A clock.
- RESET_ni  in  1  asynchronous, active-low reset.
- CLEAR_i  in  1  single-cycle pulse; starts a clear sweep.
- BUSY_o  out  1  clear sweep in progress.
- REQ_0_i / REQ_1_i  in  1  access request; held until granted.
- WE_0_i / WE_1_i  in  1  1 = write, 0 = read.
- ADDR_0_i / ADDR_1_i  in  DEPTH_LOG2  word address.
- WDATA_0_i / WDATA_1_i  in  18  write data.
- BE_0_i / BE_1_i  in  2  byte enables: bit1 = {17,15:8}, bit0 = {16,7:0}.
- GNT_0_o / GNT_1_o  out  1  grant. An access is accepted on the edge where REQ and GNT are both high.
- RVALID_0_o / RVALID_1_o  out  1  read data valid for that requester.
- RDATA_0_o / RDATA_1_o  out  18  read data; zero when the matching RVALID is low.
- RAM_WEN_o, RAM_REN_o  out  1  port A write and read enables.
- RAM_ADDR_o  out  14  {word address, 4'b0000}.
- RAM_BE_o  out  2  port A byte enables.
- RAM_WDATA_o  out  18  port A write data.
- RAM_RDATA_i  in  18  port A read data, valid 1 cycle after the read is accepted.
- RAM_WMODE_o, RAM_RMODE_o  out  3  constant 3'b010 (x18).
- RAM_FMODE_o  out  1  constant 0.

## Operation

- Controller states: CLEAR, IDLE.
- Reset entry:
  - CLEAR_ON_RESET=1: enter CLEAR with the sweep counter at 0.
  - CLEAR_ON_RESET=0: enter IDLE.
- CLEAR state:
  - Each cycle drives RAM_WEN_o=1, RAM_BE_o=2'b11, RAM_WDATA_o=CLEAR_VALUE, address = counter; the counter increments.
  - After writing address 2^DEPTH_LOG2-1, go to IDLE.
  - GNT_0_o and GNT_1_o stay 0.
  - BUSY_o=1.
  - CLEAR_i is ignored while already in CLEAR.
- IDLE + CLEAR_i: go to CLEAR with the counter at 0. No grant is issued that cycle.
- IDLE arbitration:
  - The grant is combinational from REQ and the priority pointer; at most one grant per cycle.
  - When only one requester asserts REQ, it is granted.
  - When both assert REQ, the requester not granted most recently wins.
  - The pointer resets to "requester 0 preferred" and updates on every accepted access.
- Accepted write: the RAM drive is combinational from the winner's ADDR, WDATA and BE with RAM_WEN_o=1; the write commits at that edge.
- Accepted read: RAM_REN_o=1. A registered owner tag captures the winner.
  - Next cycle: the owner's RVALID=1 and its RDATA=RAM_RDATA_i.
  - Reads can be accepted back-to-back every cycle.
- A read in flight when CLEAR begins still returns its data on the following cycle.
- RAM_WEN_o and RAM_REN_o are never both 1.

## Timing

- Reset values:
  - GNT_x_o, RVALID_x_o, RAM_WEN_o, RAM_REN_o = 0.
  - RDATA_x_o = 0.
  - BUSY_o = CLEAR_ON_RESET.
  - Counter = 0; pointer = requester 0.
- While RESET_ni is low, no RAM enables are asserted.
- Clear sweep: the first write (address 0) commits on the first rising edge after reset release. The 2^DEPTH_LOG2-th write commits on edge N.
- After edge N, BUSY_o=0 and GNT may assert in that same cycle.
- Read latency: REQ/GNT accepted at edge k, RVALID high for the cycle following edge k (one cycle).
- Write throughput is 1 per cycle.
- A write followed by a read of the same address on the next edge returns the new data.
- Reset asserted mid-sweep aborts the sweep; the sweep restarts from address 0 on release.

## Test plan

- Reset clear (DEPTH_LOG2=10): release reset with the array prefilled with 18'h3FFFF.
  - Expect exactly 1024 write cycles to addresses 0..1023 with data 0.
  - BUSY_o falls after edge 1024.
  - A subsequent read of address 5 returns 18'h00000.
- Single requester: requester 0 writes address 10 with 18'h2A5A5, BE=11, then reads address 10.
  - RVALID_0_o is high one cycle after the read grant, with RDATA_0_o=18'h2A5A5.
  - RVALID_1_o stays 0.
- Byte enables: write address 3 with 18'h3FFFF, BE=11; then write 18'h00000 with BE=01; then read.
  - Read returns 18'h2FF00.
- Contention: both requesters hold REQ with reads for 4 cycles immediately after clear.
  - Grants are 0,1,0,1.
  - RVALIDs alternate one cycle later with correct per-owner data.
- CLEAR_i mid-traffic: pulse CLEAR_i one cycle after requester 1's read is accepted.
  - RVALID_1_o still returns the old data.
  - GNTs stay low for 1024 cycles.
  - Later reads return CLEAR_VALUE.
- Reset mid-sweep at counter 300.
  - After release, the sweep restarts at address 0 and performs 1024 writes.
  - No RVALID or GNT pulses occur during the sweep.
